icache_plru: RTL and testbench

Parametrised set-associative instruction cache with tree pseudo-LRU replacement, invalid-way-first victim selection and a multi-cycle flush sequencer. It sits between the fetch stage (CPU side) and the instruction memory port (MEM side). Lookups complete in one cycle on a hit. A miss fetches one full line through a request/valid handshake and then replays as a hit.

---
 rtl/icache_plru_if.sv | 30 +++
 rtl/icache_plru.sv | 190 +++++++++++++++++++
 tb/tb_icache_plru.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_plru_if.sv
// Fetch-side and memory-side signal bundle for icache_plru.
// slave is the cache's view; master is the view of whoever drives the fetch and fill traffic.
interface icache_plru_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int WORD_WIDTH = 32,
   parameter int LINE_WIDTH = 128,
   parameter int CNT_WIDTH  = 32
);
   logic                  cpu_req_i;
   logic [ADDR_WIDTH-1:0] cpu_addr_i;
   logic                  cpu_valid_o;
   logic [WORD_WIDTH-1:0] cpu_inst_o;
   logic                  flush_i;
   logic                  busy_o;
   logic                  mem_req_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic                  mem_valid_i;
   logic [LINE_WIDTH-1:0] mem_line_i;
   logic [CNT_WIDTH-1:0]  hit_cnt_o;
   logic [CNT_WIDTH-1:0]  miss_cnt_o;

   modport slave (
      input  cpu_req_i, cpu_addr_i, flush_i, mem_valid_i, mem_line_i,
      output cpu_valid_o, cpu_inst_o, busy_o, mem_req_o, mem_addr_o, hit_cnt_o, miss_cnt_o
   );
   modport master (
      output cpu_req_i, cpu_addr_i, flush_i, mem_valid_i, mem_line_i,
      input  cpu_valid_o, cpu_inst_o, busy_o, mem_req_o, mem_addr_o, hit_cnt_o, miss_cnt_o
   );
endinterface

// File: rtl/icache_plru.sv
// Set-associative instruction cache: tree pseudo-LRU, invalid-way-first fill, one-set-per-cycle flush.
// Hit/miss performance counters exist only when ICACHE_PERF_CNT_EN is defined.
module icache_plru #(
   parameter int LINE_WIDTH = 128,
   parameter int WORD_WIDTH = 32,
   parameter int NUM_WAYS   = 4,
   parameter int NUM_SETS   = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input logic          clk,
   input logic          rst,
   icache_plru_if.slave bus
);
   localparam int OFF_W = $clog2(LINE_WIDTH / WORD_WIDTH);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int LOG_W = $clog2(NUM_WAYS);
   localparam int LSB   = 2 + OFF_W;
   localparam int TAG_W = ADDR_WIDTH - LSB - IDX_W;

   typedef enum logic [1:0] {IDLE, MISS, FLUSH} state_e;

   state_e                            state_q, state_d;
   logic [ADDR_WIDTH-1:LSB]           laddr_q, laddr_d;
   logic                              pend_q, pend_d;
   logic [IDX_W-1:0]                  fcnt_q, fcnt_d;
   logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d;
   logic [NUM_SETS-1:0][NUM_WAYS-2:0] plru_q, plru_d;
   logic [TAG_W-1:0]                  tag_mem  [NUM_SETS][NUM_WAYS];
   logic [LINE_WIDTH-1:0]             data_mem [NUM_SETS][NUM_WAYS];

   // Tree nodes are heap-ordered (root 0); a 0 bit points at the lower half.
   function automatic logic [LOG_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] t);
      logic [LOG_W-1:0] node;
      node = '0;
      plru_victim = '0;
      for (int l = 0; l < LOG_W; l++) begin
         plru_victim[LOG_W-1-l] = t[node];
         node = LOG_W'(2 * int'(node) + 1 + int'(t[node]));
      end
   endfunction

   function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] t,
                                                      input logic [LOG_W-1:0]    w);
      logic [LOG_W-1:0] node;
      node = '0;
      plru_touch = t;
      for (int l = 0; l < LOG_W; l++) begin
         plru_touch[node] = ~w[LOG_W-1-l];
         node = LOG_W'(2 * int'(node) + 1 + int'(w[LOG_W-1-l]));
      end
   endfunction

   logic [OFF_W-1:0]    req_off;
   logic [IDX_W-1:0]    req_idx, fill_idx;
   logic [TAG_W-1:0]    req_tag, fill_tag;
   logic [NUM_WAYS-1:0] way_hit;
   logic [LOG_W-1:0]    hit_way, victim;
   logic                lookup_hit, fill_we;
   logic                unused_addr_bits;

   assign req_off          = bus.cpu_addr_i[2 +: OFF_W];
   assign req_idx          = bus.cpu_addr_i[LSB +: IDX_W];
   assign req_tag          = bus.cpu_addr_i[ADDR_WIDTH-1 -: TAG_W];
   assign fill_idx         = laddr_q[LSB +: IDX_W];
   assign fill_tag         = laddr_q[ADDR_WIDTH-1 -: TAG_W];
   assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

   generate
      for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
         assign way_hit[w] = valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag);
      end
   endgenerate

   assign lookup_hit = (state_q == IDLE) && bus.cpu_req_i && (|way_hit);
   assign fill_we    = (state_q == MISS) && bus.mem_valid_i;

   always_comb begin
      hit_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if (way_hit[w]) hit_way = LOG_W'(w);
   end

   // An invalid way always wins over the tree's choice, lowest index first.
   always_comb begin
      victim = plru_victim(plru_q[fill_idx]);
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if (!valid_q[fill_idx][w]) victim = LOG_W'(w);
   end

   always_comb begin
      state_d = state_q;
      laddr_d = laddr_q;
      pend_d  = pend_q;
      fcnt_d  = fcnt_q;
      valid_d = valid_q;
      plru_d  = plru_q;
      case (state_q)
         IDLE: begin
            if (lookup_hit) plru_d[req_idx] = plru_touch(plru_q[req_idx], hit_way);
            if (bus.flush_i) begin
               state_d = FLUSH;
               fcnt_d  = '0;
            end else if (bus.cpu_req_i && !lookup_hit) begin
               state_d = MISS;
               laddr_d = bus.cpu_addr_i[ADDR_WIDTH-1:LSB];
            end
         end
         MISS: begin
            if (bus.flush_i) pend_d = 1'b1;
            if (bus.mem_valid_i) begin
               valid_d[fill_idx][victim] = 1'b1;
               plru_d[fill_idx]          = plru_touch(plru_q[fill_idx], victim);
               pend_d                    = 1'b0;
               fcnt_d                    = '0;
               state_d                   = (pend_q || bus.flush_i) ? FLUSH : IDLE;
            end
         end
         FLUSH: begin
            valid_d[fcnt_q] = '0;
            plru_d[fcnt_q]  = '0;
            fcnt_d          = fcnt_q + 1'b1;
            if (fcnt_q == IDX_W'(NUM_SETS - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         laddr_q <= '0;
         pend_q  <= 1'b0;
         fcnt_q  <= '0;
         valid_q <= '0;
         plru_q  <= '0;
      end else begin
         state_q <= state_d;
         laddr_q <= laddr_d;
         pend_q  <= pend_d;
         fcnt_q  <= fcnt_d;
         valid_q <= valid_d;
         plru_q  <= plru_d;
      end
   end

   // Tag/data arrays carry no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_mem[fill_idx][victim]  <= fill_tag;
         data_mem[fill_idx][victim] <= bus.mem_line_i;
      end
   end

   assign bus.cpu_valid_o = lookup_hit;
   assign bus.cpu_inst_o  = lookup_hit ? data_mem[req_idx][hit_way][req_off*WORD_WIDTH +: WORD_WIDTH] : '0;
   assign bus.mem_req_o   = (state_q == MISS);
   assign bus.mem_addr_o  = (state_q == MISS) ? {laddr_q, {LSB{1'b0}}} : '0;
   assign bus.busy_o      = (state_q != IDLE);

`ifdef ICACHE_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   logic                 miss_evt;

   assign miss_evt = (state_q == IDLE) && !bus.flush_i && bus.cpu_req_i && !lookup_hit;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (lookup_hit && !(&hit_cnt_q))  hit_cnt_d  = hit_cnt_q + 1'b1;
      if (miss_evt && !(&miss_cnt_q))   miss_cnt_d = miss_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign bus.hit_cnt_o  = hit_cnt_q;
   assign bus.miss_cnt_o = miss_cnt_q;
`else
   assign bus.hit_cnt_o  = '0;
   assign bus.miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_icache_plru.sv
// Directed bench for icache_plru: a way-timestamp cache model checked every cycle, plus literal pins.
module tb_icache_plru;
   localparam int LW = 128, WW = 32, NW = 4, NS = 16, AW = 32, CW = 32;
`ifdef ICACHE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   localparam logic [127:0] LINE1 = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
   localparam logic [127:0] LINE2 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   icache_plru_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) bus ();
   icache_plru #(.LINE_WIDTH(LW), .WORD_WIDTH(WW), .NUM_WAYS(NW), .NUM_SETS(NS),
                 .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_vec = 0, n_bad = 0;

   // literal expectations for the current cycle, set by the stimulus
   bit          pin_en = 0, pinc_en = 0;
   string       pin_nm = "";
   bit          pin_v, pin_m, pin_b;
   logic [31:0] pin_i, pin_a, pin_hc, pin_mc;

   // model: per way valid/tag/line and the time of its last touch (0 = untouched since clear)
   bit           m_v   [NS][NW];
   logic [23:0]  m_tag [NS][NW];
   logic [127:0] m_line[NS][NW];
   longint       m_st  [NS][NW];
   longint       now_t = 0;
   int           mode = 0;   // 0 idle, 1 miss, 2 flush
   logic [31:0]  m_laddr = 0;
   bit           m_pend = 0;
   int           m_left = 0;
   logic [31:0]  m_hc = 0, m_mc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void clear_all();
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++) begin
            m_v[s][w]  = 1'b0;
            m_st[s][w] = 0;
         end
   endfunction

   // Tree PLRU seen from above: each subtree steers away from the half holding its most recently touched way.
   function automatic int pick_victim(input int s);
      int lo, sz, half, bw;
      longint best;
      for (int w = 0; w < NW; w++) if (!m_v[s][w]) return w;
      lo = 0;
      sz = NW;
      while (sz > 1) begin
         half = sz / 2;
         best = 0;
         bw   = -1;
         for (int w = lo; w < lo + sz; w++)
            if (m_st[s][w] > best) begin best = m_st[s][w]; bw = w; end
         if (bw >= 0 && bw < lo + half) lo = lo + half;
         sz = half;
      end
      return lo;
   endfunction

   always @(negedge clk) begin : cmp
      int s, wd, hw, v, fs;
      logic [23:0] tg;
      bit ev, em, eb;
      logic [31:0] ei, ea, ehc, emc;
      s  = int'((bus.cpu_addr_i / 32'd16) % 32'd16);
      wd = int'((bus.cpu_addr_i / 32'd4) % 32'd4);
      tg = 24'(bus.cpu_addr_i / 32'd256);
      hw = -1;
      if (mode == 0 && bus.cpu_req_i === 1'b1)
         for (int w = 0; w < NW; w++)
            if (m_v[s][w] && m_tag[s][w] == tg) hw = w;
      ev = (hw >= 0);
      ei = 0;
      if (ev) ei = m_line[s][hw][wd*32 +: 32];
      em  = (mode == 1);
      ea  = em ? m_laddr : 32'h0;
      eb  = (mode != 0);
      ehc = PERF ? m_hc : 32'h0;
      emc = PERF ? m_mc : 32'h0;

      chk("cpu_valid_o", 64'(bus.cpu_valid_o), 64'(ev));
      chk("cpu_inst_o",  64'(bus.cpu_inst_o),  64'(ei));
      chk("mem_req_o",   64'(bus.mem_req_o),   64'(em));
      chk("mem_addr_o",  64'(bus.mem_addr_o),  64'(ea));
      chk("busy_o",      64'(bus.busy_o),      64'(eb));
      chk("hit_cnt_o",   64'(bus.hit_cnt_o),   64'(ehc));
      chk("miss_cnt_o",  64'(bus.miss_cnt_o),  64'(emc));
      if (pin_en) begin
         chk({pin_nm, " valid"},       64'(bus.cpu_valid_o), 64'(pin_v));
         chk({pin_nm, " inst"},        64'(bus.cpu_inst_o),  64'(pin_i));
         chk({pin_nm, " mem_req"},     64'(bus.mem_req_o),   64'(pin_m));
         chk({pin_nm, " mem_addr"},    64'(bus.mem_addr_o),  64'(pin_a));
         chk({pin_nm, " busy"},        64'(bus.busy_o),      64'(pin_b));
         chk({pin_nm, " model valid"}, 64'(ev),              64'(pin_v));
         chk({pin_nm, " model inst"},  64'(ei),              64'(pin_i));
      end
      if (pinc_en) begin
         chk("counter hit",        64'(bus.hit_cnt_o),  64'(pin_hc));
         chk("counter miss",       64'(bus.miss_cnt_o), 64'(pin_mc));
         chk("model counter hit",  64'(ehc),            64'(pin_hc));
         chk("model counter miss", 64'(emc),            64'(pin_mc));
      end

      if (rst) begin
         clear_all();
         mode = 0; m_pend = 0; m_left = 0; m_hc = 0; m_mc = 0;
      end else begin
         case (mode)
            0: begin
               if (ev) begin
                  now_t++;
                  m_st[s][hw] = now_t;
                  if (m_hc != 32'hFFFF_FFFF) m_hc++;
               end
               if (bus.flush_i) begin
                  clear_all(); mode = 2; m_left = NS;
               end else if (bus.cpu_req_i && !ev) begin
                  mode = 1;
                  m_laddr = bus.cpu_addr_i & 32'hFFFF_FFF0;
                  if (m_mc != 32'hFFFF_FFFF) m_mc++;
               end
            end
            1: begin
               if (bus.flush_i) m_pend = 1;
               if (bus.mem_valid_i) begin
                  fs = int'((m_laddr / 32'd16) % 32'd16);
                  v  = pick_victim(fs);
                  m_v[fs][v]    = 1'b1;
                  m_tag[fs][v]  = 24'(m_laddr / 32'd256);
                  m_line[fs][v] = bus.mem_line_i;
                  now_t++;
                  m_st[fs][v] = now_t;
                  if (m_pend) begin clear_all(); mode = 2; m_left = NS; end
                  else mode = 0;
                  m_pend = 0;
               end
            end
            default: begin
               m_left--;
               if (m_left == 0) mode = 0;
            end
         endcase
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         pin_en  = 0;
         pinc_en = 0;
      end
   endtask

   task automatic pin(input string nm, input bit v, input logic [31:0] i,
                      input bit m, input logic [31:0] a, input bit b);
      pin_nm = nm; pin_v = v; pin_i = i; pin_m = m; pin_a = a; pin_b = b;
      pin_en = 1;
   endtask

   task automatic pinc(input logic [31:0] hc, input logic [31:0] mc);
      pin_hc = PERF ? hc : 32'h0;
      pin_mc = PERF ? mc : 32'h0;
      pinc_en = 1;
   endtask

   function automatic logic [127:0] mk(input logic [31:0] a);
      return {a ^ 32'h3000_0000, a ^ 32'h2000_0000, a ^ 32'h1000_0000, a ^ 32'hF000_0000};
   endfunction

   // miss, fill on the first request cycle, replay hit
   task automatic fill(input logic [31:0] a, input logic [127:0] ln, input string nm);
      int wi;
      wi = int'((a / 32'd4) % 32'd4);
      bus.cpu_req_i = 1; bus.cpu_addr_i = a;
      pin({nm, " miss"}, 0, 0, 0, 0, 0);
      tick(1);
      bus.mem_valid_i = 1; bus.mem_line_i = ln;
      pin({nm, " req"}, 0, 0, 1, a & 32'hFFFF_FFF0, 1);
      tick(1);
      bus.mem_valid_i = 0;
      pin({nm, " replay"}, 1, ln[wi*32 +: 32], 0, 0, 0);
      tick(1);
      bus.cpu_req_i = 0;
   endtask

   initial begin
      bus.cpu_req_i = 0; bus.cpu_addr_i = 0; bus.flush_i = 0;
      bus.mem_valid_i = 0; bus.mem_line_i = 0;
      rst = 1;
      pin("reset", 0, 0, 0, 0, 0); pinc(0, 0);
      tick(2);
      rst = 0;

      // cold miss, replay, hits in the same line, counters
      bus.cpu_req_i = 1; bus.cpu_addr_i = 32'h0000_1004;
      pin("cold T", 0, 0, 0, 0, 0);                        tick(1);
      pin("cold T+1", 0, 0, 1, 32'h0000_1000, 1);          tick(1);
      bus.mem_valid_i = 1; bus.mem_line_i = LINE1;
      pin("cold fill", 0, 0, 1, 32'h0000_1000, 1);         tick(1);
      bus.mem_valid_i = 0;
      pin("cold replay", 1, 32'hBBBB_BBBB, 0, 0, 0);       tick(1);
      bus.cpu_addr_i = 32'h0000_100C;
      pin("hit after fill", 1, 32'hDDDD_DDDD, 0, 0, 0);    tick(1);
      bus.cpu_addr_i = 32'h0000_1000;
      pin("hit word0", 1, 32'hAAAA_AAAA, 0, 0, 0);         tick(1);
      bus.cpu_req_i = 0;
      pin("idle", 0, 0, 0, 0, 0); pinc(3, 1);              tick(1);

      // stray fill data in IDLE is ignored
      bus.mem_valid_i = 1; bus.mem_line_i = LINE2;
      pin("stray fill", 0, 0, 0, 0, 0);                    tick(1);
      bus.mem_valid_i = 0;

      // reset during a miss
      bus.cpu_req_i = 1; bus.cpu_addr_i = 32'h0000_5000;   tick(1);
      rst = 1;
      pin("pre-reset miss", 0, 0, 1, 32'h0000_5000, 1);    tick(1);
      rst = 0; bus.cpu_req_i = 0;
      pin("after reset", 0, 0, 0, 0, 0); pinc(0, 0);       tick(1);
      bus.mem_valid_i = 1; bus.mem_line_i = LINE2;
      pin("late fill ignored", 0, 0, 0, 0, 0);             tick(1);
      bus.mem_valid_i = 0;
      fill(32'h0000_1004, LINE1, "refill after reset");

      // PLRU: fill set 0 with four tags, touch tag 0, force an eviction
      rst = 1; tick(1); rst = 0;
      fill(32'h0000_0000, mk(32'h0000_0000), "plru fill0");
      fill(32'h0000_0100, mk(32'h0000_0100), "plru fill1");
      fill(32'h0000_0200, mk(32'h0000_0200), "plru fill2");
      fill(32'h0000_0300, mk(32'h0000_0300), "plru fill3");
      bus.cpu_req_i = 1; bus.cpu_addr_i = 32'h0000_0000;
      pin("plru touch0", 1, 32'hF000_0000, 0, 0, 0);       tick(1);
      fill(32'h0000_0400, mk(32'h0000_0400), "plru evict");
      bus.cpu_req_i = 1; bus.cpu_addr_i = 32'h0000_0000;
      pin("plru keep0", 1, 32'hF000_0000, 0, 0, 0);        tick(1);
      bus.cpu_addr_i = 32'h0000_0100;
      pin("plru keep1", 1, 32'hF000_0100, 0, 0, 0);        tick(1);
      bus.cpu_addr_i = 32'h0000_0300;
      pin("plru keep3", 1, 32'hF000_0300, 0, 0, 0);        tick(1);
      fill(32'h0000_0200, mk(32'h0000_0200), "plru evicted2");

      // flush in IDLE with a same-cycle hit; a second pulse mid-flush is ignored
      fill(32'h0000_1004, LINE1, "pre flush");
      bus.cpu_req_i = 1; bus.cpu_addr_i = 32'h0000_1004; bus.flush_i = 1;
      pin("flush with hit", 1, 32'hBBBB_BBBB, 0, 0, 0);    tick(1);
      bus.cpu_req_i = 0;
      for (int i = 0; i < NS; i++) begin
         bus.flush_i = (i == 5);
         pin("flush busy", 0, 0, 0, 0, 1);
         tick(1);
      end
      bus.flush_i = 0;
      pin("flush done", 0, 0, 0, 0, 0);                    tick(1);
      fill(32'h0000_1004, LINE1, "post flush");

      // flush during a miss: fill lands, then a full flush runs
      bus.cpu_req_i = 1; bus.cpu_addr_i = 32'h0000_2008;
      pin("fdm miss", 0, 0, 0, 0, 0);                      tick(1);
      bus.flush_i = 1;
      pin("fdm pulse", 0, 0, 1, 32'h0000_2000, 1);         tick(1);
      bus.flush_i = 0;
      pin("fdm wait", 0, 0, 1, 32'h0000_2000, 1);          tick(1);
      bus.mem_valid_i = 1; bus.mem_line_i = LINE2;
      pin("fdm fill", 0, 0, 1, 32'h0000_2000, 1);          tick(1);
      bus.mem_valid_i = 0; bus.cpu_req_i = 0;
      for (int i = 0; i < NS; i++) begin
         pin("fdm flush busy", 0, 0, 0, 0, 1);
         tick(1);
      end
      pin("fdm done", 0, 0, 0, 0, 0);                      tick(1);
      fill(32'h0000_2008, LINE2, "fdm line gone");

      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
